// File: rtl/rd53_afe_dig_pkg.sv
// rd53_afe_dig_pkg: shared constants, FSM state and hit record type for the AFE hit digitizer.
package rd53_afe_dig_pkg;
    localparam int TOT_W_DEF  = 4;
    localparam int BCID_W_DEF = 8;
    localparam int TOT_NOHIT  = 2**TOT_W_DEF - 1;
    localparam int TOT_MAX    = 2**TOT_W_DEF - 2;
    typedef enum logic {IDLE, COUNT} state_e;
    typedef struct packed {
        logic [TOT_W_DEF-1:0]  tot;
        logic [BCID_W_DEF-1:0] bcid;
    } hit_rec_t;
endpackage

// File: rtl/rd53_hit_fifo.sv
// rd53_hit_fifo: synchronous first-word-fall-through FIFO for hit records.
module rd53_hit_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic wr_en, rd_en;
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // A pop frees the slot, so a push into a full FIFO is allowed in the same cycle.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign data_out = empty ? '0 : mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_en ? wr_q + 1'b1 : wr_q;
            rd_q <= rd_en ? rd_q + 1'b1 : rd_q;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= data_in;
    end
endmodule

// File: rtl/rd53_afe_hit_digitizer.sv
// rd53_afe_hit_digitizer: synchronises the AFE HIT pulse, measures ToT, tags the
// leading-edge BCID and queues {ToT, BCID} records for region readout.
module rd53_afe_hit_digitizer
    import rd53_afe_dig_pkg::*;
#(
    parameter int TOT_W      = TOT_W_DEF,
    parameter int BCID_W     = BCID_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int OVF_W      = 8
) (
    input  logic              CLK_BX,
    input  logic              RST_B,
    input  logic              HIT,
    input  logic              EN_DIGITIZE,
    input  logic [BCID_W-1:0] BCID,
    output logic              HIT_OR,
    output logic              BUSY,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [TOT_W-1:0]  OUT_TOT,
    output logic [BCID_W-1:0] OUT_BCID,
    output logic [OVF_W-1:0]  OVF_CNT
);
    localparam logic [TOT_W-1:0] TOT_SAT = TOT_W'(2**TOT_W - 2);
    logic h1_q, hs_q, hd_q, rise, push, pop, full, empty;
    logic [1:0] pr_q, pr_d;
    state_e state_q, state_d;
    logic [TOT_W-1:0] cnt_q, cnt_d;
    logic [BCID_W-1:0] bcid_q, bcid_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic [TOT_W+BCID_W-1:0] head;
    always_ff @(posedge CLK_BX) begin
        if (!RST_B) begin
            h1_q    <= 1'b0;
            hs_q    <= 1'b0;
            hd_q    <= 1'b0;
            pr_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            bcid_q  <= '0;
            ovf_q   <= '0;
        end else begin
            h1_q    <= HIT;
            hs_q    <= h1_q;
            hd_q    <= hs_q;
            pr_q    <= pr_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcid_q  <= bcid_d;
            ovf_q   <= ovf_d;
        end
    end
    // Edges are trusted only once h_d holds a real sample, so a HIT still high across reset is not seen as a rise.
    always_comb begin
        pr_d    = (&pr_q) ? pr_q : pr_q + 2'd1;
        rise    = hs_q & ~hd_q & (&pr_q);
        state_d = state_q;
        cnt_d   = cnt_q;
        bcid_d  = bcid_q;
        push    = 1'b0;
        if (state_q == IDLE) begin
            if (rise && EN_DIGITIZE) begin
                state_d = COUNT;
                cnt_d   = TOT_W'(1);
                bcid_d  = BCID;
            end
        end else if (hs_q) begin
            cnt_d = (cnt_q == TOT_SAT) ? cnt_q : cnt_q + 1'b1;
        end else begin
            push    = 1'b1;
            state_d = IDLE;
        end
        pop   = ~empty & OUT_READY;
        ovf_d = (push & full & ~pop & ~(&ovf_q)) ? ovf_q + 1'b1 : ovf_q;
    end
    rd53_hit_fifo #(.WIDTH(TOT_W + BCID_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (CLK_BX),
        .rst_b   (RST_B),
        .push    (push),
        .data_in ({cnt_q, bcid_q}),
        .full    (full),
        .pop     (pop),
        .data_out(head),
        .empty   (empty)
    );
    assign HIT_OR    = hs_q;
    assign BUSY      = state_q == COUNT;
    assign OUT_VALID = ~empty;
    assign OUT_TOT   = head[TOT_W+BCID_W-1:BCID_W];
    assign OUT_BCID  = head[BCID_W-1:0];
    assign OVF_CNT   = ovf_q;
endmodule

// File: tb/tb_rd53_afe_hit_digitizer.sv
// tb_rd53_afe_hit_digitizer: directed hits with a scoreboard queue checked by a readout monitor.
module tb_rd53_afe_hit_digitizer;
    import rd53_afe_dig_pkg::*;
    logic clk = 1'b0;
    logic RST_B, HIT, EN_DIGITIZE, OUT_READY;
    logic HIT_OR, BUSY, OUT_VALID;
    logic [7:0] bc = 8'h00;
    logic [3:0] OUT_TOT;
    logic [7:0] OUT_BCID, OVF_CNT;
    hit_rec_t sb[$];
    int n_chk = 0;
    int n_pass = 0;
    int busy_cnt = 0;
    rd53_afe_hit_digitizer dut (
        .CLK_BX     (clk),
        .RST_B      (RST_B),
        .HIT        (HIT),
        .EN_DIGITIZE(EN_DIGITIZE),
        .BCID       (bc),
        .HIT_OR     (HIT_OR),
        .BUSY       (BUSY),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_TOT    (OUT_TOT),
        .OUT_BCID   (OUT_BCID),
        .OVF_CNT    (OVF_CNT)
    );
    always #5 clk = ~clk;
    always @(posedge clk) bc <= bc + 8'd1;
    always @(negedge clk) if (BUSY) busy_cnt++;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // HIT high for n edges; EN_DIGITIZE toggles after edge tog (0 = never); the BCID
    // seen by the digitizer is the one two edges after HIT rises.
    task automatic hit(input int n, input bit en, input int tog, input bit exp, input int gap);
        hit_rec_t r;
        EN_DIGITIZE = en;
        HIT = 1'b1;
        r.tot  = 4'((n > TOT_MAX) ? TOT_MAX : n);
        r.bcid = bc + 8'd2;
        if (exp) sb.push_back(r);
        for (int i = 1; i <= n; i++) begin
            tick(1);
            if (i == tog) EN_DIGITIZE = ~EN_DIGITIZE;
        end
        HIT = 1'b0;
        EN_DIGITIZE = 1'b1;
        tick(gap);
    endtask

    always @(negedge clk) begin
        if (RST_B && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) check("unexpected_record", int'(OUT_VALID), 0);
            else begin
                hit_rec_t e;
                e = sb.pop_front();
                check("rec_tot", int'(OUT_TOT), int'(e.tot));
                check("rec_bcid", int'(OUT_BCID), int'(e.bcid));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hit_rec_t r;
        RST_B = 1'b0;
        HIT = 1'b0;
        EN_DIGITIZE = 1'b1;
        OUT_READY = 1'b1;
        tick(3);
        check("rst_hit_or", int'(HIT_OR), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_valid", int'(OUT_VALID), 0);
        check("rst_tot", int'(OUT_TOT), 0);
        check("rst_bcid", int'(OUT_BCID), 0);
        check("rst_ovf", int'(OVF_CNT), 0);
        RST_B = 1'b1;
        tick(4);
        // 5-cycle hit tagged with BCID 0x10, latency to OUT_VALID
        do tick(1); while (bc != 8'h0E);
        HIT = 1'b1;
        r.tot = 4'd5;
        r.bcid = 8'h10;
        sb.push_back(r);
        tick(5);
        HIT = 1'b0;
        tick(1);
        tick(1);
        check("latency_k1_valid", int'(OUT_VALID), 0);
        tick(1);
        check("latency_k2_valid", int'(OUT_VALID), 1);
        tick(3);
        // long hit saturates ToT at 14
        begin
            int b0;
            b0 = busy_cnt;
            hit(30, 1'b1, 0, 1'b1, 6);
            check("busy_cycles", busy_cnt - b0, 30);
        end
        // overflow with consumer stalled
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) hit(2, 1'b1, 0, i < 4, 2);
        tick(4);
        check("ovf_cnt", int'(OVF_CNT), 1);
        check("stall_valid", int'(OUT_VALID), 1);
        check("stall_tot", int'(OUT_TOT), 2);
        check("stall_bcid", int'(OUT_BCID), int'(sb[0].bcid));
        OUT_READY = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        check("drain_left", sb.size(), 0);
        // enable handling
        hit(4, 1'b0, 0, 1'b0, 4);
        hit(4, 1'b0, 3, 1'b0, 4);
        hit(6, 1'b1, 4, 1'b1, 6);
        // back-to-back hits
        hit(3, 1'b1, 0, 1'b1, 1);
        hit(4, 1'b1, 0, 1'b1, 8);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
        check("b2b_left", sb.size(), 0);
        // reset in the middle of a hit
        HIT = 1'b1;
        tick(6);
        check("mid_busy", int'(BUSY), 1);
        RST_B = 1'b0;
        tick(2);
        check("midrst_valid", int'(OUT_VALID), 0);
        check("midrst_ovf", int'(OVF_CNT), 0);
        check("midrst_busy", int'(BUSY), 0);
        check("midrst_hit_or", int'(HIT_OR), 0);
        RST_B = 1'b1;
        tick(5);
        HIT = 1'b0;
        tick(10);
        check("post_rst_valid", int'(OUT_VALID), 0);
        check("final_left", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rd53_afe_hit_digitizer.md
Name: rd53_afe_hit_digitizer

Overview:
- Digital receiver for the discriminator HIT output of the RD53 analog front end (AFE) pixel model.
- Synchronises the asynchronous HIT pulse to the bunch-crossing clock and measures time-over-threshold (ToT) in clock cycles.
- Tags each hit with the BCID of its leading edge.
- Queues {ToT, BCID} records behind a valid/ready interface for the pixel-region readout logic.

Parameters:
- TOT_W, 4, ToT field width; code 2**TOT_W-1 is reserved for "no hit", so maximum reported ToT is 2**TOT_W-2.
- BCID_W, 8, BCID field width.
- FIFO_DEPTH, 4, hit record buffer depth; must be a power of two and at least 2.
- OVF_W, 8, width of the dropped-hit counter.

Ports:
- CLK_BX  in  1  bunch-crossing clock, 40 MHz.
- RST_B  in  1  synchronous active-low reset.
- HIT  in  1  asynchronous discriminator output from the AFE.
- EN_DIGITIZE  in  1  enables acceptance of new leading edges.
- BCID  in  BCID_W  free-running bunch-crossing counter.
- HIT_OR  out  1  synchronised HIT level, for the region OR.
- BUSY  out  1  high while a hit is being measured.
- OUT_VALID  out  1  a hit record is available.
- OUT_READY  in  1  consumer accepts the record.
- OUT_TOT  out  TOT_W  ToT of the head record.
- OUT_BCID  out  BCID_W  leading-edge BCID of the head record.
- OVF_CNT  out  OVF_W  count of dropped hits, saturating.

Behaviour:
- Reset (RST_B low at a CLK_BX edge):
  - Sync flops, state, counter, FIFO pointers and OVF_CNT are cleared.
  - All outputs are 0.
  - Reset mid-hit discards the hit in progress; no record is produced.
- Synchroniser: two-flop chain HIT -> h1 -> h_s, plus delayed copy h_d.
  - HIT_OR = h_s.
  - rise = h_s & ~h_d; fall = ~h_s & h_d.
- FSM, two states:
  - IDLE: on rise & EN_DIGITIZE -> COUNT. Load cnt=1 and bcid_r=BCID (the BCID in the cycle h_s is first high).
  - IDLE: a rise while EN_DIGITIZE=0 is ignored for the whole pulse; the FSM stays in IDLE until the next rise.
  - COUNT: while h_s=1, cnt increments and saturates at 2**TOT_W-2 (14 for the default).
  - COUNT: on fall, push {cnt, bcid_r} and return to IDLE.
  - ToT = number of CLK_BX cycles h_s was high, clipped at 14.
  - Deasserting EN_DIGITIZE during COUNT does not abort; the current hit completes and is pushed.
  - A rise in the cycle immediately after a fall is accepted; there is no dead time beyond synchronisation.
- BUSY = (state==COUNT).
- FIFO: first-word-fall-through.
  - OUT_VALID = not empty; OUT_TOT and OUT_BCID present the head record.
  - Pop when OUT_VALID & OUT_READY.
  - OUT_TOT and OUT_BCID hold stable while OUT_VALID=1 and OUT_READY=0.
  - Push when FIFO full with no simultaneous pop: the record is dropped and OVF_CNT increments, saturating at 2**OVF_W-1.
  - Push and pop in the same cycle on a full FIFO: both succeed, with no drop.
  - Simultaneous push and pop on an empty FIFO: the push is stored; OUT_VALID rises next cycle (no combinational bypass).
- Latency:
  - The first CLK_BX edge sampling HIT low is edge k.
  - h_s goes low at k+1; fall is detected in cycle k+1; the push occurs at edge k+2.
  - OUT_VALID=1 from edge k+2.
- BCID wrap: OUT_BCID is the raw captured value, with no correction. A hit spanning a BCID wrap reports its pre-wrap BCID.

Decomposition:
- Package rd53_afe_dig_pkg holds:
  - TOT_NOHIT constant (2**TOT_W-1) and TOT_MAX (2**TOT_W-2).
  - The FSM state enum (IDLE, COUNT).
  - The hit record typedef {tot, bcid}.
- One sub-module: rd53_hit_fifo, a synchronous FWFT FIFO.
  - Parameterised by width and depth.
  - Ports: push/data_in/full and pop/data_out/empty.
- Synchroniser, FSM and overflow counter stay in the top module.

Test Plan:
- HIT high for 5 cycles with BCID=0x10 at h_s rise, OUT_READY=1 -> one record OUT_TOT=5, OUT_BCID=0x10; OUT_VALID first high 2 edges after the first low sample of HIT.
- HIT high for 30 cycles -> OUT_TOT=14 (saturated), never 15; BUSY high for 30 cycles.
- OUT_READY=0, five 2-cycle hits -> four records held, OVF_CNT=1; release OUT_READY -> records drain in order with ToT=2 and correct BCIDs.
- Rise with EN_DIGITIZE=0 -> no record. EN_DIGITIZE dropped mid-hit -> that hit is still reported.
- RST_B low during COUNT -> OUT_VALID=0, OVF_CNT=0, no record after reset release even though HIT is still high.
- Back-to-back hits (3 high, 1 low, 4 high) -> two records, ToT 3 and 4, with BCIDs 4 apart.
